// File: rtl/divider_iter.sv
// divider_iter: iterative restoring radix-2 integer divider.
// One operation yields quotient and remainder. Signed or unsigned is chosen per
// operation. Divide-by-zero and signed MIN/-1 are resolved without iterating.
// Result registers hold their values until the next completed operation.
module divider_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             start,
    input  logic             abort,
    input  logic             divs,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             q_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;       // raw dividend, returned as remainder on divide-by-zero
    logic [WIDTH-1:0] dvd_reg;     // dividend magnitude; quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvsr_reg;    // divisor magnitude
    logic [WIDTH-1:0] prem_reg;    // partial remainder (always < divisor, so WIDTH bits suffice)
    logic [CW-1:0]    cnt_reg;     // quotient bits still to produce, minus one
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic             dz_reg;      // current op is divide-by-zero
    logic             ov_reg;      // current op is signed MIN / -1

    // Operand magnitudes for the preload; |MIN| wraps to MIN, which is the
    // correct unsigned value 2^(WIDTH-1).
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             is_zero_div;
    logic             is_ovf;

    always_comb begin
        a_mag       = (divs && a[WIDTH-1]) ? -a : a;
        b_mag       = (divs && b[WIDTH-1]) ? -b : b;
        is_zero_div = (b == ZERO);
        is_ovf      = divs && (a == MIN_VAL) && (b == ONES);
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The difference is known
    // to be below the divisor, so it is computed modulo 2^WIDTH.
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;

    always_comb begin
        trial      = {prem_reg, dvd_reg[WIDTH-1]};
        trial_ge   = (trial >= {1'b0, dvsr_reg});
        trial_diff = trial[WIDTH-1:0] - dvsr_reg;
    end

    // Final result selection: apply the signs to the magnitude result, or
    // substitute the defined special-case values.
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        q_final = sign_q_reg ? -dvd_reg : dvd_reg;
        r_final = sign_r_reg ? -prem_reg : prem_reg;
        if (dz_reg) begin
            q_final = ONES;
            r_final = a_reg;
        end else if (ov_reg) begin
            q_final = MIN_VAL;
            r_final = ZERO;
        end
    end

    // Control FSM plus datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            a_reg       <= ZERO;
            dvd_reg     <= ZERO;
            dvsr_reg    <= ZERO;
            prem_reg    <= ZERO;
            cnt_reg     <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            dz_reg      <= 1'b0;
            ov_reg      <= 1'b0;
            quotient    <= ZERO;
            remainder   <= ZERO;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            q_zero      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy <= 1'b0;
                    // abort takes priority over a simultaneous start
                    if (start && !abort) begin
                        a_reg <= a;
                        if (is_zero_div) begin
                            dz_reg    <= 1'b1;
                            ov_reg    <= 1'b0;
                            state_reg <= FIX;
                        end else if (is_ovf) begin
                            dz_reg    <= 1'b0;
                            ov_reg    <= 1'b1;
                            state_reg <= FIX;
                        end else begin
                            dz_reg     <= 1'b0;
                            ov_reg     <= 1'b0;
                            dvd_reg    <= a_mag;
                            dvsr_reg   <= b_mag;
                            prem_reg   <= ZERO;
                            cnt_reg    <= CNT_LAST;
                            sign_q_reg <= divs & (a[WIDTH-1] ^ b[WIDTH-1]);
                            sign_r_reg <= divs & a[WIDTH-1];
                            state_reg  <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (abort && busy) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        busy     <= 1'b1;
                        prem_reg <= trial_ge ? trial_diff : trial[WIDTH-1:0];
                        dvd_reg  <= {dvd_reg[WIDTH-2:0], trial_ge};
                        if (cnt_reg == '0) begin
                            state_reg <= FIX;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_ONE;
                        end
                    end
                end

                FIX: begin
                    if (abort && busy) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= dz_reg;
                        overflow    <= ov_reg;
                        q_zero      <= (q_final == ZERO);
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/divider_iter.md
Name: divider_iter

Overview:
- Parametrised iterative integer divider; successor to the fixed 32-bit CPU divider.
- Produces quotient and remainder together from one operation.
- Adds signed/unsigned selection per operation, a start/busy/done handshake, abort, and defined divide-by-zero and signed-overflow results with flags.
- Sits beside the ALU. The CPU or DMA issues an operation and stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; accepted only in a cycle where busy=0
abort  in  1  cancel in-flight operation
divs  in  1  1 = signed (two's complement), 0 = unsigned; sampled with start
a  in  WIDTH  dividend; sampled with start
b  in  WIDTH  divisor; sampled with start
quotient  out  WIDTH  registered quotient
remainder  out  WIDTH  registered remainder
div_by_zero  out  1  last completed operation had b=0
overflow  out  1  last completed op was signed MIN / -1
q_zero  out  1  quotient==0 for last completed op
busy  out  1  operation in flight
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; all outputs 0; internal registers 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 captures divs, a, b.
  - b==0 → FIX with special-case flag set.
  - divs=1 and a==MIN (1 followed by zeros) and b==all-ones → FIX with overflow flag set.
  - Otherwise → CALC.
  - CALC preload: for signed ops, |a| and |b| as WIDTH-bit unsigned (|MIN| = 2^(WIDTH-1) fits); for unsigned ops, raw values. Also preload sign_q = a[W-1]^b[W-1] and sign_r = a[W-1] (both 0 when unsigned), partial remainder (WIDTH+1 bits) = 0, and bit counter = WIDTH-1.
- CALC: restoring radix-2, one quotient bit per clock, MSB first.
  - trial = {prem[W-1:0], dvd[MSB]}.
  - If trial >= divisor: prem = trial - divisor, q bit = 1. Else prem = trial, q bit = 0.
  - Shift the dividend left.
  - Counter reaches 0 → FIX.
- FIX: one clock; write outputs; done=1; → IDLE.
  - Normal case: quotient = sign_q ? -q : q; remainder = sign_r ? -r : r.
  - Divide by zero: quotient = all-ones; remainder = a (raw); div_by_zero=1; overflow=0.
  - Overflow: quotient = MIN; remainder = 0; overflow=1; div_by_zero=0.
  - q_zero reflects the final quotient.
- busy: 1 from the edge after accepted start until the FIX edge; 0 in IDLE.
- Latency, counted from the accepting edge E0:
  - Normal: done visible after edge E(WIDTH+1), i.e. WIDTH+1 clocks.
  - Special cases: done after E1.
  - done is high for exactly one cycle.
- Result outputs and flags hold until the next completion. They do not change on start, abort, or during CALC.
- start while busy: ignored, no effect.
- start in the cycle done=1: accepted, since busy=0 then.
- abort=1 with busy=1: → IDLE at next edge; busy=0; no done pulse; outputs unchanged. abort in IDLE is a no-op. abort and start together in IDLE: abort wins, start ignored.
- Reset mid-operation: immediate return to IDLE; outputs cleared; no done.
- Invariant for non-special ops: quotient*b + remainder == a (mod 2^WIDTH).
- Sign rule: remainder sign matches the dividend; |remainder| < |b|.

Test Plan:
- WIDTH=32, unsigned 100/7 → quotient=14, remainder=2, q_zero=0; done exactly 33 clocks after the accepting edge; busy high for 32 cycles.
- Signed -7/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/-2 → quotient=0xFFFFFFFD, remainder=1. Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- 5/0, both modes → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done 1 clock after start. Unsigned 0/9 → quotient=0, remainder=0, q_zero=1.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1, 1-clock latency. Same operands unsigned → quotient=0, remainder=0x80000000, overflow=0, 33-clock latency.
- Start 100/7; pulse start with 9/3 at cycle 10 → ignored, result 14/2. Start again in the done cycle → accepted, second result follows 33 clocks later.
- Start 100/7; abort at cycle 5 → busy drops next edge, no done, prior outputs held. Separately, assert reset at cycle 12 → all outputs 0 immediately, including when reset is not aligned to a clock edge.
